// File: rtl/instr_step_sequencer.sv
// ---------------------------------------------------------------------------
// instr_step_sequencer
//   Moore control sequencer for the bus-based datapath. It fetches an
//   instruction, decodes it from IR, and issues the per-step bus and latch
//   enables. Three-register ALU ops write Rin[Ra]; MUL/DIV write LO then HI.
//
// Ports
//   Clock, Clear        : rising-edge clock, synchronous active-low reset
//   run                 : level enable, sampled in IDLE and at instruction end
//   IR                  : instruction register contents (valid from T3)
//   mem_ready           : memory read data valid this cycle (T1 handshake)
//   PCout..HIin         : single-bit datapath / Z / HI / LO enables
//   Rout, Rin           : one-hot register bus-drive / load selects
//   alu_op              : opcode to the ALU, driven only in T4
//   step                : present state code (debug)
//   illegal_op          : one-cycle pulse in T3 for an undecodable opcode
// ---------------------------------------------------------------------------
module instr_step_sequencer #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4,
    parameter int OPCODE_W  = 5
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                run,
    input  logic [DATA_W-1:0]   IR,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                ZHighIn,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                LOin,
    output logic                HIin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OPCODE_W-1:0] alu_op,
    output logic [3:0]          step,
    output logic                illegal_op
);

    localparam int RA_HI = DATA_W - OPCODE_W - 1;
    localparam int RB_HI = RA_HI - REG_SEL_W;
    localparam int RC_HI = RB_HI - REG_SEL_W;
    localparam int RC_LO = RC_HI - REG_SEL_W + 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
    } state_t;

    state_t state_q, state_d;

    logic [OPCODE_W-1:0]  op;
    logic [REG_SEL_W-1:0] ra, rb, rc;
    logic                 is_r3, is_md;
    logic                 unused_ir_low;

    assign op = IR[DATA_W-1 -: OPCODE_W];
    assign ra = IR[RA_HI -: REG_SEL_W];
    assign rb = IR[RB_HI -: REG_SEL_W];
    assign rc = IR[RC_HI -: REG_SEL_W];
    assign unused_ir_low = ^IR[RC_LO-1:0];

    assign is_r3 = (op <= OPCODE_W'(13));
    assign is_md = (op == OPCODE_W'(14)) || (op == OPCODE_W'(15));

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // Next-state logic; run only matters in IDLE and at instruction end.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   begin
                if (is_r3 || is_md) state_d = S_T4;
                else                state_d = run ? S_T0 : S_IDLE;
            end
            S_T4:   state_d = S_T5;
            S_T5:   begin
                if (is_md) state_d = S_T6;
                else       state_d = run ? S_T0 : S_IDLE;
            end
            S_T6:   state_d = run ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Moore output decode from present state and IR fields.
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLowIn     = 1'b0;
        ZHighIn    = 1'b0;
        Zlowout    = 1'b0;
        ZHighout   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Rout       = '0;
        Rin        = '0;
        alu_op     = '0;
        illegal_op = 1'b0;
        unique case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = mem_ready;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_r3) begin
                    Rout = onehot(rb);
                    Yin  = 1'b1;
                end else if (is_md) begin
                    Rout = onehot(ra);
                    Yin  = 1'b1;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            S_T4: begin
                alu_op = op;
                ZLowIn = 1'b1;
                if (is_md) begin
                    Rout    = onehot(rb);
                    ZHighIn = 1'b1;
                end else begin
                    Rout = onehot(rc);
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_md) LOin = 1'b1;
                // R0 is hardwired: the result is driven but never latched.
                else if (ra != '0) Rin = onehot(ra);
            end
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign step = state_q;

endmodule

// File: tb/tb_instr_step_sequencer.sv
module tb_instr_step_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        run = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
    logic        ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin;
    logic [15:0] Rout, Rin;
    logic [4:0]  alu_op;
    logic [3:0]  step;
    logic        illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    instr_step_sequencer #(
        .DATA_W(32), .NUM_REGS(16), .REG_SEL_W(4), .OPCODE_W(5)
    ) dut (
        .Clock(Clock), .Clear(Clear), .run(run), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
        .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .step(step), .illegal_op(illegal_op)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end, want end");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] ctl;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  alu;
        logic        ill;
    } obs_t;

    localparam logic [13:0] M_PCOUT = 14'h2000, M_MARIN = 14'h1000, M_INCPC = 14'h0800,
                            M_READ  = 14'h0400, M_MDRIN = 14'h0200, M_MDROUT = 14'h0100,
                            M_IRIN  = 14'h0080, M_YIN   = 14'h0040, M_ZLI = 14'h0020,
                            M_ZHI   = 14'h0010, M_ZLO   = 14'h0008, M_ZHO = 14'h0004,
                            M_LOIN  = 14'h0002, M_HIIN  = 14'h0001;

    obs_t exp_q[$];
    bit   mr_q[$];

    function automatic obs_t actual();
        obs_t o;
        o.st   = step;
        o.ctl  = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
                  ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin};
        o.rout = Rout;
        o.rin  = Rin;
        o.alu  = alu_op;
        o.ill  = illegal_op;
        return o;
    endfunction

    function automatic void push(input logic [3:0] st, input logic [13:0] c,
                                 input logic [15:0] ro, input logic [15:0] ri,
                                 input logic [4:0] al, input logic il, input bit mr);
        obs_t o;
        o.st = st; o.ctl = c; o.rout = ro; o.rin = ri; o.alu = al; o.ill = il;
        exp_q.push_back(o);
        mr_q.push_back(mr);
    endfunction

    // Reference: expand one instruction into its expected cycle-by-cycle
    // observation list, with `waits` not-ready cycles in the memory read.
    function automatic void build(input logic [31:0] ir, input int waits);
        int unsigned op, ra, rb, rc;
        logic [15:0] rin_v;
        exp_q.delete();
        mr_q.delete();
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        rin_v = (ra == 0) ? 16'h0 : (16'h1 << ra);
        push(4'd1, M_PCOUT | M_MARIN | M_INCPC, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        for (int w = 0; w < waits; w++) push(4'd2, M_READ, 0, 0, 0, 0, 1'b0);
        push(4'd2, M_READ | M_MDRIN, 0, 0, 0, 0, 1'b1);
        push(4'd3, M_MDROUT | M_IRIN, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        if (op <= 13) begin
            push(4'd4, M_YIN, 16'h1 << rb, 0, 0, 0, 1'($urandom_range(0, 1)));
            push(4'd5, M_ZLI, 16'h1 << rc, 0, 5'(op), 0, 1'($urandom_range(0, 1)));
            push(4'd6, M_ZLO, 0, rin_v, 0, 0, 1'($urandom_range(0, 1)));
        end else if (op <= 15) begin
            push(4'd4, M_YIN, 16'h1 << ra, 0, 0, 0, 1'($urandom_range(0, 1)));
            push(4'd5, M_ZLI | M_ZHI, 16'h1 << rb, 0, 5'(op), 0, 1'($urandom_range(0, 1)));
            push(4'd6, M_ZLO | M_LOIN, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            push(4'd7, M_ZHO | M_HIIN, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        end else begin
            push(4'd4, 14'h0, 0, 0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end
    endfunction

    // Entered at posedge+1 with the DUT in T0; leaves at posedge+1 after
    // the last executed entry. run drops from entry drop_at onward.
    task automatic exec_queue(input string name, input int n_run, input int drop_at);
        obs_t got;
        for (int i = 0; i < n_run && i < exp_q.size(); i++) begin
            if (i >= drop_at) run = 1'b0;
            mem_ready = mr_q[i];
            @(negedge Clock);
            got = actual();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h want %h", name, i, got, exp_q[i]);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset();
        obs_t got;
        Clear = 1'b0;
        run   = 1'b1;
        IR    = 32'h5A1B8000;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            @(negedge Clock);
            got = actual();
            n_tests++;
            if (got !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h want %h", i, got, obs_t'(0));
            end
        end
        Clear = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_r3();
        IR = 32'h5A1B8000;
        build(IR, 0);
        exec_queue("r3_shl", exp_q.size(), 1000);
    endtask

    task automatic test_mem_wait();
        IR = 32'h08A20000;
        build(IR, 3);
        exec_queue("mem_wait", exp_q.size(), 1000);
    endtask

    task automatic test_md();
        IR = 32'h71180000;
        build(IR, 0);
        exec_queue("md_mul", exp_q.size(), 1000);
    endtask

    task automatic test_illegal();
        IR = 32'hF8000000;
        build(IR, 0);
        exec_queue("illegal", exp_q.size(), 1000);
    endtask

    task automatic test_r0_guard();
        IR = 32'h00100000;
        build(IR, 0);
        exec_queue("r0_guard", exp_q.size(), 1000);
    endtask

    task automatic test_clear_mid();
        obs_t got;
        IR = 32'h5A1B8000;
        build(IR, 1);
        exec_queue("clear_mid", 5, 1000);
        Clear = 1'b0;
        @(negedge Clock);
        got = actual();
        n_tests++;
        if (got !== exp_q[5]) begin
            n_fail++;
            $display("FAIL clear_mid_t4: got %h want %h", got, exp_q[5]);
        end
        @(posedge Clock); #1;
        @(negedge Clock);
        got = actual();
        n_tests++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL clear_mid_idle: got %h want %h", got, obs_t'(0));
        end
        Clear = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_run_drop();
        obs_t got;
        IR = {5'd3, 4'd9, 4'd5, 4'd12, 15'h1234};
        build(IR, 2);
        exec_queue("run_drop", exp_q.size(), 4);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            got = actual();
            n_tests++;
            if (got !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL run_drop_idle cyc %0d: got %h want %h", i, got, obs_t'(0));
            end
            if (i == 1) run = 1'b1;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            IR = {5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  15'($urandom)};
            build(IR, $urandom_range(0, 3));
            exec_queue("random", exp_q.size(), 1000);
        end
    endtask

    initial begin
        test_reset();
        test_r3();
        test_mem_wait();
        test_md();
        test_illegal();
        test_r0_guard();
        test_clear_mid();
        test_run_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_step_sequencer.md
Name: instr_step_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the bus-based DataPath.
- Replaces hand-driven T0..T5 control pulses with a Moore FSM.
- Fetches an instruction, decodes opcode/register fields from IR, and issues per-step bus/latch enables for three-register ALU ops and two-register MUL/DIV (HI/LO write).
- Adds a memory-ready handshake, an illegal-opcode flag and an R0 write guard.

Parameters:
- DATA_W, 32, IR/data width.
- NUM_REGS, 16, number of general registers; one-hot select width.
- REG_SEL_W, 4, register field width in IR (2**REG_SEL_W == NUM_REGS).
- OPCODE_W, 5, opcode field width; IR[DATA_W-1 -: OPCODE_W].

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Clear  in  1  synchronous active-low reset.
- run  in  1  level enable; sequencer starts or continues fetching while high.
- IR  in  DATA_W  current IR register contents.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath enables.
- ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin  out  1 each  Z/HI/LO enables.
- Rout  out  NUM_REGS  one-hot register-to-bus select.
- Rin  out  NUM_REGS  one-hot register load select.
- alu_op  out  OPCODE_W  ALU operation code to the ALU.
- step  out  4  present state encoding (debug).
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- IR fields: op = IR[31:27]; Ra = IR[26:23]; Rb = IR[22:19]; Rc = IR[18:15]. Positions scale with parameters, MSB-first, contiguous.
- All outputs are combinational decodes of state and IR (Moore). No output is asserted in IDLE.
- Reset: Clock edge with Clear=0 → IDLE. All outputs 0, step=0. Overrides any state, including mid-instruction (abort, no register write).
- States and step codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7.
- IDLE: run=1 → T0; otherwise stay.
- T0: PCout, MARin, IncPC. → T1.
- T1: Read=1 every cycle in T1. MDRin=mem_ready. Stay while mem_ready=0; mem_ready=1 → T2. Wait length is unbounded.
- T2: MDRout, IRin. → T3. IR is valid from T3 on.
- Op classes:
  - R3 = op 00000..01101 (three-register).
  - MD = 01110 (mul), 01111 (div).
  - Anything else is illegal.
- T3, illegal: illegal_op=1, no other outputs, → IDLE if run=0 else T0.
- T3, R3: Rout[Rb], Yin. → T4.
- T3, MD: Rout[Ra], Yin. → T4.
- T4, R3: Rout[Rc], alu_op=op, ZLowIn. → T5.
- T4, MD: Rout[Rb], alu_op=op, ZLowIn, ZHighIn. → T5.
- T5, R3: Zlowout, Rin[Ra]. → end.
- T5, MD: Zlowout, LOin. → T6.
- T6 (MD only): ZHighout, HIin. → end.
- alu_op: 0 outside T4.
- End of instruction: → T0 if run=1, else IDLE. run is sampled only at instruction end or in IDLE; dropping run mid-instruction completes the instruction.
- R0 guard: Rin bit 0 is never asserted. Ra=0 write is discarded; Zlowout is still asserted. Rout bit 0 is allowed.
- Rout/Rin: at most one bit high in any cycle; all zero outside the listed states.
- Latency with mem_ready already high in T1: R3 = 6 cycles (T0..T5); MD = 7 cycles.

Test Plan:
- Clear=0 for 2 cycles with run=1 → step=0, all outputs 0. Release Clear → T0 on next edge: PCout=MARin=IncPC=1.
- run=1, mem_ready=1, IR=0x5A1B8000 (shl R4,R3,R7) → T3 Rout=0x0008 + Yin; T4 Rout=0x0080 + alu_op=01011 + ZLowIn; T5 Zlowout + Rin=0x0010; next cycle T0.
- mem_ready held 0 for 3 cycles in T1 → Read high for 4 cycles, MDRin high only in the 4th, IRin one cycle later.
- IR=0x71180000 (mul R2,R3) → T3 Rout=0x0004; T4 ZLowIn=ZHighIn=1, alu_op=01110; T5 LOin; T6 HIin; Rin stays 0 throughout.
- IR=0xF8000000 (op 11111) → illegal_op pulse in T3, no Yin/Rin, returns to T0 (run=1). Separately, IR=0x00100000 (Ra=0) → T5 Zlowout=1, Rin=0.
- Clear=0 during T4 → next cycle IDLE, Rin never asserted. run dropped in T2 → instruction completes through T5, then IDLE.
